// File: rtl/dtw_score_collector.sv
// rtl/dtw_score_collector.sv - collects the minimum DTW cost and its position over one scoring pass
module dtw_score_collector #(
   parameter int WIDTH = 18,
   parameter int IDXW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDXW-1:0]  ref_len,
   input  logic [WIDTH-1:0] threshold,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_cost,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_score,
   output logic [IDXW-1:0]  res_index,
   output logic             res_hit
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [WIDTH-1:0] COST_MAX = '1;
   localparam logic [IDXW-1:0]  IDX_ONE  = {{(IDXW-1){1'b0}}, 1'b1};

   state_t           state;
   logic [IDXW-1:0]  cnt;
   logic [IDXW-1:0]  len_q;
   logic [WIDTH-1:0] thr_q;
   logic [WIDTH-1:0] best;
   logic [IDXW-1:0]  best_idx;

   logic             better;
   logic             last;
   logic [WIDTH-1:0] next_best;
   logic [IDXW-1:0]  next_idx;

   // Strict compare keeps the earliest position on equal costs.
   assign better    = in_cost < best;
   assign next_best = better ? in_cost : best;
   assign next_idx  = better ? cnt : best_idx;
   assign last      = (cnt == (len_q - IDX_ONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         len_q     <= '0;
         thr_q     <= '0;
         best      <= '0;
         best_idx  <= '0;
         busy      <= 1'b0;
         res_valid <= 1'b0;
         res_score <= '0;
         res_index <= '0;
         res_hit   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  len_q    <= ref_len;
                  thr_q    <= threshold;
                  cnt      <= '0;
                  best     <= COST_MAX;
                  best_idx <= '0;
                  busy     <= 1'b1;
                  if (ref_len == '0) begin
                     // Empty pass reports the "no match" sentinel immediately.
                     state     <= DONE;
                     res_valid <= 1'b1;
                     res_score <= COST_MAX;
                     res_index <= '0;
                     res_hit   <= (COST_MAX <= threshold);
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (in_valid) begin
                  cnt      <= cnt + IDX_ONE;
                  best     <= next_best;
                  best_idx <= next_idx;
                  if (last) begin
                     state     <= DONE;
                     res_valid <= 1'b1;
                     res_score <= next_best;
                     res_index <= next_idx;
                     res_hit   <= (next_best <= thr_q);
                  end
               end
            end
            DONE: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               res_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/dtw_score_collector.md
DTW_SCORE_COLLECTOR -- requirements
Module: dtw_score_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 18: bit width of the DTW cost values produced by the processing-element chain.
REQ-002 SHALL have parameter IDXW, default 16: bit width of reference-position counters and indices.
REQ-003 SHALL have `clk`, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have `rst`, input, 1 bit: reset; synchronous, active-high.
REQ-005 SHALL have `start`, input, 1 bit: begin a scoring pass; sampled only in IDLE.
REQ-006 SHALL have `ref_len`, input, IDXW bits: number of cost samples in the pass; latched on accepted `start`.
REQ-007 SHALL have `threshold`, input, WIDTH bits: match threshold; latched on accepted `start`.
REQ-008 SHALL have `in_valid`, input, 1 bit: `in_cost` is valid this cycle.
REQ-009 SHALL have `in_cost`, input, WIDTH bits: unsigned DTW cost from the last PE of the chain.
REQ-010 SHALL have `busy`, output, 1 bit: high in RUN and DONE.
REQ-011 SHALL have `res_valid`, output, 1 bit: result available.
REQ-012 SHALL have `res_ready`, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have `res_score`, output, WIDTH bits: minimum cost seen in the pass.
REQ-014 SHALL have `res_index`, output, IDXW bits: zero-based sample position of `res_score`.
REQ-015 SHALL have `res_hit`, output, 1 bit: high when `res_score` <= latched threshold.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 In IDLE with `start`=1 and `ref_len`!=0, the block SHALL latch `ref_len` and `threshold`, clear the sample counter, set best to all-ones and best index to 0, and enter RUN on the next edge.
REQ-018 In IDLE with `start`=1 and `ref_len`=0, the block SHALL enter DONE directly with score all-ones, index 0 and `res_hit` = (all-ones <= threshold).
REQ-019 In RUN, each cycle with `in_valid`=1 SHALL accept one sample at position = counter and then increment the counter.
REQ-020 An accepted sample SHALL update best and index when `in_cost` < best (strict, unsigned); on a tie the earliest index SHALL be kept.
REQ-021 When the accepted sample has counter = `ref_len`-1, the block SHALL enter DONE on that edge.
REQ-022 `res_valid` SHALL be high in the cycle after the last sample is accepted (1-cycle latency), and the result SHALL include that sample.
REQ-023 In DONE, `res_valid` SHALL stay high and `res_score`/`res_index`/`res_hit` SHALL stay stable until `res_valid`&&`res_ready`; on that edge the FSM SHALL go to IDLE.
REQ-024 `in_valid` SHALL be ignored in IDLE and DONE; `start` SHALL be ignored in RUN and DONE.
REQ-025 `start` SHALL NOT be accepted in the same cycle as the result handshake; it is accepted from IDLE only, i.e. one cycle later at the earliest.
REQ-026 The counter SHALL NOT wrap within a pass; `ref_len`=2^IDXW-1 is the maximum pass length.
REQ-027 `in_valid` gaps (bubbles) in RUN SHALL stall the pass without changing state.
REQ-028 `busy` SHALL equal (state != IDLE); all outputs SHALL be registered.

Reset
REQ-029 When `rst`=1 at a clock edge, the block SHALL enter IDLE and clear `busy`, `res_valid`, `res_score`, `res_index`, `res_hit`, the counter and the latched parameters to 0, regardless of state.
REQ-030 Reset in RUN or DONE SHALL abandon the pass; no result SHALL be presented afterwards.

Verification
REQ-031 Scenario: `ref_len`=4, costs 9,5,7,5 back-to-back, threshold 6 -> `res_valid` 1 cycle after the 4th sample, score 5, index 1, hit 1.
REQ-032 Scenario: `ref_len`=3, costs 10,20,30 with a 2-cycle bubble, threshold 9 -> score 10, index 0, hit 0; `busy` high throughout.
REQ-033 Scenario: `res_ready` held low 5 cycles -> `res_valid` and result fields stable for 5 cycles; IDLE the cycle after `res_ready`=1.
REQ-034 Scenario: `ref_len`=0, threshold all-ones -> DONE next cycle, score all-ones (0x3FFFF), index 0, hit 1.
REQ-035 Scenario: `rst` pulsed after 2 of 4 samples -> `busy`=0 and `res_valid`=0 next cycle; later samples ignored; a new `start` runs a clean pass.
REQ-036 Scenario: `start` and `in_valid` pulses applied in DONE -> ignored; the result is unchanged.
